// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator result path.
// Holds the converter FSM encoding and the leading-zero blanking rule.
package calc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int BCD_DIGITS  = 4;
    localparam int MAX_DISPLAY = 9999;
    localparam int BIN_W       = 16;
    localparam int BCD_W       = 20;

    // The ones digit is never blanked, so a zero result still shows "0".
    function automatic logic [3:0] blank_mask(input logic [3:0] n4,
                                              input logic [3:0] n3,
                                              input logic [3:0] n2,
                                              input logic       ovf);
        logic [3:0] m;
        m    = 4'b0000;
        m[3] = (n4 == 4'd0);
        m[2] = m[3] & (n3 == 4'd0);
        m[1] = m[2] & (n2 == 4'd0);
        m[0] = 1'b0;
        if (ovf) m = 4'b0000;
        return m;
    endfunction

endpackage

// File: rtl/bcd_dabble_step.sv
// Add-3 correction over a 20-bit packed BCD word, applied before each
// double-dabble shift so no nibble exceeds 9 after doubling.
module bcd_dabble_step
    import calc_pkg::*;
(
    input  logic [BCD_W-1:0] i_bcd,
    output logic [BCD_W-1:0] o_bcd
);

    for (genvar g = 0; g < BCD_W / 4; g++) begin : g_nibble
        logic [3:0] w_nib;
        assign w_nib              = i_bcd[g*4 +: 4];
        assign o_bcd[g*4 +: 4]    = (w_nib >= 4'd5) ? (w_nib + 4'd3) : w_nib;
    end

endmodule

// File: rtl/value_to_digits.sv
// Sequential binary-to-BCD converter with leading-zero blanking, overflow
// flag and a free-running digit scanner for the 7-segment driver.
module value_to_digits
    import calc_pkg::*;
#(
    parameter int SCAN_DIV = 50000
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic [BIN_W-1:0]  value,
    input  logic              load,
    output logic              busy,
    output logic              done,
    output logic [3:0]        num1,
    output logic [3:0]        num2,
    output logic [3:0]        num3,
    output logic [3:0]        num4,
    output logic [3:0]        blank,
    output logic              overflow,
    output logic [1:0]        scan_sel,
    output logic [3:0]        scan_digit,
    output logic              scan_blank,
    output state_t            dbg_state
);

    localparam int                SCAN_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

    state_t              r_state;
    state_t              w_next_state;
    logic [BIN_W-1:0]    r_bin;
    logic [BCD_W-1:0]    r_bcd;
    logic [BCD_W-1:0]    w_bcd_adj;
    logic [3:0]          r_cnt;
    logic [3:0]          r_num1, r_num2, r_num3, r_num4;
    logic [3:0]          r_blank;
    logic                r_ovf;
    logic                r_done;
    logic [SCAN_W-1:0]   r_scan_cnt;
    logic [1:0]          r_scan_sel;

    bcd_dabble_step u_step (
        .i_bcd (r_bcd),
        .o_bcd (w_bcd_adj)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next_state;
    end

    // Loads are only accepted in IDLE, which includes the done-pulse cycle.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (load) w_next_state = SHIFT;
            SHIFT:   if (r_cnt == 4'd15) w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_bin   <= '0;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_num1  <= '0;
            r_num2  <= '0;
            r_num3  <= '0;
            r_num4  <= '0;
            r_blank <= 4'b1110;
            r_ovf   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (load) begin
                        r_bin <= value;
                        r_bcd <= '0;
                        r_cnt <= '0;
                    end
                end
                SHIFT: begin
                    {r_bcd, r_bin} <= {w_bcd_adj, r_bin} << 1;
                    r_cnt          <= r_cnt + 4'd1;
                end
                DONE: begin
                    r_num1  <= r_bcd[3:0];
                    r_num2  <= r_bcd[7:4];
                    r_num3  <= r_bcd[11:8];
                    r_num4  <= r_bcd[15:12];
                    r_ovf   <= |r_bcd[19:16];
                    r_blank <= blank_mask(r_bcd[15:12], r_bcd[11:8], r_bcd[7:4],
                                          |r_bcd[19:16]);
                    r_done  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Scan prescaler runs regardless of conversion activity.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_scan_cnt <= '0;
            r_scan_sel <= '0;
        end else if (r_scan_cnt == SCAN_LAST) begin
            r_scan_cnt <= '0;
            r_scan_sel <= r_scan_sel + 2'd1;
        end else begin
            r_scan_cnt <= r_scan_cnt + 1'b1;
        end
    end

    always_comb begin
        scan_digit = r_num1;
        case (r_scan_sel)
            2'd0: scan_digit = r_num1;
            2'd1: scan_digit = r_num2;
            2'd2: scan_digit = r_num3;
            2'd3: scan_digit = r_num4;
            default: scan_digit = r_num1;
        endcase
    end

    assign scan_blank = r_blank[r_scan_sel];
    assign scan_sel   = r_scan_sel;
    assign busy       = (r_state != IDLE) | r_done;
    assign done       = r_done;
    assign num1       = r_num1;
    assign num2       = r_num2;
    assign num3       = r_num3;
    assign num4       = r_num4;
    assign blank      = r_blank;
    assign overflow   = r_ovf;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_value_to_digits.sv
// Self-checking bench for value_to_digits: latency, blanking, overflow,
// ignored loads, reset abort, back-to-back loads and digit scanning.
module tb_value_to_digits;
    import calc_pkg::*;

    logic        clk;
    logic        reset;
    logic [15:0] value;
    logic        load;
    logic        busy, done, overflow, scan_blank;
    logic [3:0]  num1, num2, num3, num4, blank, scan_digit;
    logic [1:0]  scan_sel;
    state_t      dbg_state;

    int total = 0;
    int bad   = 0;
    int scan_edges;
    logic [20:0] exp_q[$];

    value_to_digits #(.SCAN_DIV(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .value      (value),
        .load       (load),
        .busy       (busy),
        .done       (done),
        .num1       (num1),
        .num2       (num2),
        .num3       (num3),
        .num4       (num4),
        .blank      (blank),
        .overflow   (overflow),
        .scan_sel   (scan_sel),
        .scan_digit (scan_digit),
        .scan_blank (scan_blank),
        .dbg_state  (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edges since the last reset release; drives the scan expectation.
    always @(posedge clk or negedge reset) begin
        if (!reset) scan_edges <= 0;
        else        scan_edges <= scan_edges + 1;
    end

    // Reference: decimal arithmetic on the value, packed as
    // {num4, num3, num2, num1, blank, overflow}.
    function automatic logic [20:0] model(input int v);
        int d, n1, n2, n3, n4;
        logic ovf;
        logic [3:0] b;
        d   = v % 10000;
        n1  = d % 10;
        n2  = (d / 10) % 10;
        n3  = (d / 100) % 10;
        n4  = d / 1000;
        ovf = (v > MAX_DISPLAY);
        b   = 4'b0000;
        if (!ovf) begin
            b[3] = (n4 == 0);
            b[2] = (n4 == 0) && (n3 == 0);
            b[1] = (n4 == 0) && (n3 == 0) && (n2 == 0);
        end
        return {4'(n4), 4'(n3), 4'(n2), 4'(n1), b, ovf};
    endfunction

    function automatic logic [20:0] observed();
        return {num4, num3, num2, num1, blank, overflow};
    endfunction

    // driver tasks
    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0;
        load  = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic drive_load(input logic [15:0] v);
        value = v;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
    endtask

    task automatic wait_done(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
        end
    endtask

    // tests
    task automatic test_reset();
        apply_reset();
        total++;
        if ({observed(), busy, done, scan_sel} !== {4'd0, 4'd0, 4'd0, 4'd0, 4'b1110, 1'b0, 1'b0, 1'b0, 2'd0}) begin
            bad++;
            $display("FAIL reset_state: got %h want %h", {observed(), busy, done, scan_sel},
                     {4'd0, 4'd0, 4'd0, 4'd0, 4'b1110, 1'b0, 1'b0, 1'b0, 2'd0});
        end
    endtask

    task automatic test_latency();
        logic [20:0] exp;
        int done_cnt;
        exp = model(5983);
        @(negedge clk);
        drive_load(16'd5983);
        done_cnt = 0;
        for (int k = 0; k <= 18; k++) begin
            if (k > 0) @(negedge clk);
            if (done === 1'b1) done_cnt++;
            total++;
            if (busy !== (k <= 17) || done !== (k == 17)) begin
                bad++;
                $display("FAIL latency_e%0d: busy=%b done=%b want busy=%b done=%b",
                         k, busy, done, (k <= 17), (k == 17));
            end
        end
        total++;
        if (observed() !== exp || done_cnt != 1) begin
            bad++;
            $display("FAIL latency_result: got %h dones=%0d want %h dones=1", observed(), done_cnt, exp);
        end
    endtask

    task automatic test_directed();
        int vals[6] = '{7, 40, 65535, 9999, 0, 10000};
        bit seen;
        for (int i = 0; i < 6; i++) begin
            drive_load(16'(vals[i]));
            wait_done(seen);
            total++;
            if (!seen || observed() !== model(vals[i])) begin
                bad++;
                $display("FAIL directed_%0d: seen=%b got %h want %h", vals[i], seen, observed(), model(vals[i]));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_ignored_load();
        int done_cnt;
        drive_load(16'd1234);
        repeat (4) @(negedge clk);
        drive_load(16'd4321);
        done_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done === 1'b1) done_cnt++;
        end
        total++;
        if (observed() !== model(1234) || done_cnt != 1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL ignored_load: got %h dones=%0d busy=%b want %h dones=1 busy=0",
                     observed(), done_cnt, busy, model(1234));
        end
    endtask

    task automatic test_reset_abort();
        bit seen;
        drive_load(16'd5983);
        repeat (8) @(negedge clk);
        reset = 1'b0;
        #1;
        total++;
        if ({observed(), busy, done, scan_sel} !== {4'd0, 4'd0, 4'd0, 4'd0, 4'b1110, 1'b0, 1'b0, 1'b0, 2'd0}
            || dbg_state !== IDLE) begin
            bad++;
            $display("FAIL reset_abort: got %h state=%0d want %h state=0", {observed(), busy, done, scan_sel},
                     dbg_state, {4'd0, 4'd0, 4'd0, 4'd0, 4'b1110, 1'b0, 1'b0, 1'b0, 2'd0});
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        drive_load(16'd100);
        wait_done(seen);
        total++;
        if (!seen || observed() !== model(100)) begin
            bad++;
            $display("FAIL after_abort_100: seen=%b got %h want %h", seen, observed(), model(100));
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        bit seen;
        logic [15:0] v;
        exp_q.delete();
        v = 16'($urandom_range(0, 65535));
        exp_q.push_back(model(int'(v)));
        drive_load(v);
        for (int n = 0; n < 4; n++) begin
            wait_done(seen);
            if (n < 3) begin
                // load in the done cycle must start the next conversion
                v = 16'($urandom_range(0, 65535));
                value = v;
                load  = 1'b1;
            end
            total++;
            if (!seen || exp_q.size() == 0 || observed() !== exp_q[0]) begin
                bad++;
                $display("FAIL back_to_back_%0d: seen=%b got %h want %h", n, seen, observed(),
                         (exp_q.size() != 0) ? exp_q[0] : 21'h0);
            end
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            if (n < 3) begin
                exp_q.push_back(model(int'(v)));
                @(negedge clk);
                load = 1'b0;
            end
        end
    endtask

    task automatic test_random();
        bit seen;
        logic [15:0] v;
        for (int n = 0; n < 10; n++) begin
            case (n % 3)
                0: v = 16'($urandom_range(0, 65535));
                1: v = 16'($urandom_range(0, 999));
                default: v = 16'($urandom_range(9990, 10010));
            endcase
            exp_q.push_back(model(int'(v)));
            drive_load(v);
            wait_done(seen);
            total++;
            if (!seen || observed() !== exp_q[0]) begin
                bad++;
                $display("FAIL random_%0d(v=%0d): seen=%b got %h want %h", n, v, seen, observed(), exp_q[0]);
            end
            void'(exp_q.pop_front());
            @(negedge clk);
        end
    endtask

    task automatic test_scan();
        bit seen;
        logic [20:0] e;
        logic [3:0] dig[BCD_DIGITS];
        logic [3:0] bl;
        int sel;
        apply_reset();
        drive_load(16'd5983);
        wait_done(seen);
        e = model(5983);
        dig[0] = e[12:9];
        dig[1] = e[16:13];
        dig[2] = e[20:17];
        dig[3] = 4'(e[20:17] == 0 ? 0 : e[20:17]);
        dig[3] = e[20:17];
        dig[2] = e[16:13];
        dig[1] = e[12:9];
        dig[0] = e[8:5];
        bl = e[4:1];
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            sel = (scan_edges / 4) % 4;
            total++;
            if (!seen || scan_sel !== 2'(sel) || scan_digit !== dig[sel] || scan_blank !== bl[sel]) begin
                bad++;
                $display("FAIL scan_%0d: sel=%0d digit=%0d blank=%b want sel=%0d digit=%0d blank=%b",
                         i, scan_sel, scan_digit, scan_blank, sel, dig[sel], bl[sel]);
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        load  = 1'b0;
        value = '0;
        test_reset();
        test_latency();
        test_directed();
        test_ignored_load();
        test_reset_abort();
        test_back_to_back();
        test_random();
        test_scan();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
